// File: rtl/fetch_mem_unit.sv
// Instruction-fetch and memory-address unit: owns PC, instruction register and
// data-address register, and sequences fetch/execute/data accesses on one memory port.
module fetch_mem_unit #(
  parameter int unsigned ADDR_W   = 9,
  parameter int unsigned DATA_W   = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              mem_ready,
  input  logic [DATA_W-1:0] read_data,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [1:0]        mem_cmd,
  output logic [DATA_W-1:0] ins,
  output logic              ins_valid,
  input  logic              done,
  input  logic [1:0]        pc_mode,
  input  logic [ADDR_W-1:0] offset,
  input  logic [ADDR_W-1:0] target,
  input  logic              data_req,
  input  logic              data_we,
  input  logic [ADDR_W-1:0] data_addr,
  output logic              data_ack,
  output logic [DATA_W-1:0] rdata,
  input  logic              halt,
  output logic [ADDR_W-1:0] pc,
  output logic              halted
);

  typedef enum logic [2:0] {
    ST_RST   = 3'd0,
    ST_FETCH = 3'd1,
    ST_EXEC  = 3'd2,
    ST_DATA  = 3'd3,
    ST_HALT  = 3'd4
  } state_t;

  localparam logic [1:0] CMD_NONE  = 2'b00;
  localparam logic [1:0] CMD_READ  = 2'b01;
  localparam logic [1:0] CMD_WRITE = 2'b10;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   pc_q, pc_d;
  logic [DATA_W-1:0]   ins_q, ins_d;
  logic [ADDR_W-1:0]   daddr_q, daddr_d;
  logic                dwe_q, dwe_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                ins_valid_q, ins_valid_d;
  logic                data_ack_q, data_ack_d;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_RST;
      pc_q        <= RESET_PC;
      ins_q       <= '0;
      daddr_q     <= '0;
      dwe_q       <= 1'b0;
      rdata_q     <= '0;
      ins_valid_q <= 1'b0;
      data_ack_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      ins_q       <= ins_d;
      daddr_q     <= daddr_d;
      dwe_q       <= dwe_d;
      rdata_q     <= rdata_d;
      ins_valid_q <= ins_valid_d;
      data_ack_q  <= data_ack_d;
    end
  end

  // NOTE: every signal gets a default before the case so no path leaves one
  // unassigned, which would infer a latch.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    ins_d       = ins_q;
    daddr_d     = daddr_q;
    dwe_d       = dwe_q;
    rdata_d     = rdata_q;
    ins_valid_d = 1'b0;
    data_ack_d  = 1'b0;
    mem_addr    = pc_q;
    mem_cmd     = CMD_NONE;

    unique case (state_q)
      ST_RST: state_d = ST_FETCH;

      ST_FETCH: begin
        mem_cmd = CMD_READ;
        if (mem_ready) begin
          ins_d       = read_data;
          pc_d        = pc_q + 1'b1;
          ins_valid_d = 1'b1;
          state_d     = ST_EXEC;
        end
      end

      ST_EXEC: begin
        // halt beats data_req beats done; a done alongside data_req is dropped.
        if (halt) begin
          state_d = ST_HALT;
        end else if (data_req) begin
          daddr_d = data_addr;
          dwe_d   = data_we;
          state_d = ST_DATA;
        end else if (done) begin
          unique case (pc_mode)
            2'b01:   pc_d = pc_q + offset;
            2'b10:   pc_d = target;
            default: pc_d = pc_q;
          endcase
          state_d = ST_FETCH;
        end
      end

      ST_DATA: begin
        mem_addr = daddr_q;
        mem_cmd  = dwe_q ? CMD_WRITE : CMD_READ;
        if (mem_ready) begin
          if (!dwe_q) rdata_d = read_data;
          data_ack_d = 1'b1;
          state_d    = ST_EXEC;
        end
      end

      ST_HALT: state_d = ST_HALT;

      default: state_d = ST_RST;
    endcase
  end

  assign ins       = ins_q;
  assign ins_valid = ins_valid_q;
  assign data_ack  = data_ack_q;
  assign rdata     = rdata_q;
  assign pc        = pc_q;
  assign halted    = (state_q == ST_HALT);

endmodule
